// File: rtl/fifo_bit_fetch_pkg.sv
// fifo_bit_fetch shared types and constants.
// Bit buffer sizing, FSM encoding and small helpers.
package fifo_bit_fetch_pkg;

    localparam int DWIDTH = 8;
    localparam int BWIDTH = 4;
    localparam int OWIDTH = 15;
    localparam int BUF_W  = 23;
    localparam int FILL_W = 5;
    localparam int NEED_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_OUT
    } state_t;

    // Whole bytes needed to cover a shortfall of 1..15 bits.
    function automatic logic [NEED_W-1:0] bytes_needed(
        input logic [FILL_W-1:0] short_bits
    );
        logic [FILL_W-1:0] rounded;
        rounded = short_bits + FILL_W'(DWIDTH - 1);
        return NEED_W'(rounded >> 3);
    endfunction

    // Mask with the low n bits set; n = 15 gives all ones.
    function automatic logic [OWIDTH-1:0] low_mask(
        input logic [BWIDTH-1:0] n
    );
        logic [OWIDTH-1:0] m;
        for (int i = 0; i < OWIDTH; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_bit_fetch.sv
// fifo_bit_fetch: read-side bit fetcher for the encoder byte FIFO.
// Packs popped bytes LSB-first and hands out 0..15 bit chunks.
module fifo_bit_fetch
    import fifo_bit_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_one_available_i,
    input  logic [DWIDTH-1:0] fifo_data_i,
    output logic              fifo_re_o,
    input  logic              req_i,
    input  logic [BWIDTH-1:0] req_bits_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              data_valid_o,
    output logic [OWIDTH-1:0] data_o,
    output logic              stall_o
);

    state_t              state;
    logic [BUF_W-1:0]    buffer;
    logic [FILL_W-1:0]   fill;
    logic [BWIDTH-1:0]   n_q;
    logic [NEED_W-1:0]   need;
    logic [NEED_W-1:0]   issued;
    logic [NEED_W-1:0]   captured;
    logic                re_q;

    logic                pending;
    logic [FILL_W-1:0]   req_ext;
    logic [FILL_W-1:0]   fill_eff;

    // A flush in the same cycle as a request means the request sees fill=0.
    assign req_ext  = {1'b0, req_bits_i};
    assign fill_eff = flush_i ? '0 : fill;

    // Read enable and stall depend on the live FIFO flag so reads can
    // go back to back without ever exceeding the byte count needed.
    assign pending      = (state == ST_FETCH) && (issued < need);
    assign fifo_re_o    = pending && fifo_one_available_i;
    assign stall_o      = pending && !fifo_one_available_i;
    assign ready_o      = (state == ST_IDLE);
    assign data_valid_o = (state == ST_OUT);
    assign data_o       = data_valid_o
                        ? (buffer[OWIDTH-1:0] & low_mask(n_q))
                        : '0;

    // Fetch FSM with the bit buffer: insert at fill, shift out by n.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            buffer   <= '0;
            fill     <= '0;
            n_q      <= '0;
            need     <= '0;
            issued   <= '0;
            captured <= '0;
            re_q     <= 1'b0;
        end else begin
            re_q <= fifo_re_o;
            unique case (state)
                ST_IDLE: begin
                    if (flush_i) begin
                        buffer <= '0;
                        fill   <= '0;
                    end
                    if (req_i) begin
                        n_q      <= req_bits_i;
                        issued   <= '0;
                        captured <= '0;
                        if (req_ext <= fill_eff) begin
                            state <= ST_OUT;
                        end else begin
                            need  <= bytes_needed(req_ext - fill_eff);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fifo_re_o) begin
                        issued <= issued + 1'b1;
                    end
                    if (re_q) begin
                        buffer   <= buffer
                                  | (BUF_W'(fifo_data_i) << fill);
                        fill     <= fill + FILL_W'(DWIDTH);
                        captured <= captured + 1'b1;
                        if (captured + 1'b1 == need) begin
                            state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    buffer <= buffer >> n_q;
                    fill   <= fill - FILL_W'(n_q);
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_bit_fetch.sv
// tb_fifo_bit_fetch: directed bench with a bit-queue reference model.
// A FIFO model feeds the DUT; a monitor checks outputs every cycle.
module tb_fifo_bit_fetch;

    logic        clk;
    logic        reset;
    logic        favail;
    logic [7:0]  fdata;
    logic        fifo_re_o;
    logic        req;
    logic [3:0]  req_bits;
    logic        flush;
    logic        ready_o;
    logic        data_valid_o;
    logic [14:0] data_o;
    logic        stall_o;

    fifo_bit_fetch dut (
        .clk                 (clk),
        .reset               (reset),
        .fifo_one_available_i(favail),
        .fifo_data_i         (fdata),
        .fifo_re_o           (fifo_re_o),
        .req_i               (req),
        .req_bits_i          (req_bits),
        .flush_i             (flush),
        .ready_o             (ready_o),
        .data_valid_o        (data_valid_o),
        .data_o              (data_o),
        .stall_o             (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical FIFO model
    logic [7:0] fq[$];
    logic       push_en;
    logic [7:0] push_byte;

    always @(posedge clk) begin
        if (fifo_re_o && fq.size() != 0) begin
            fdata <= fq[0];
            void'(fq.pop_front());
        end
        if (push_en) fq.push_back(push_byte);
        favail <= (fq.size() != 0);
    end

    // Reference model: every byte ever written, plus a residual bit queue
    logic [7:0] stream[$];
    int         rd_ptr;
    bit         bits[$];

    int          n_cmp;
    int          n_bad;
    bit          busy;
    bit          done;
    int          cyc;
    int          rd_cnt;
    int          stall_cnt;
    logic [14:0] exp_data;
    int          exp_reads;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ready", int'(ready_o), int'(!busy));
                n_cmp++;
                if (fifo_re_o && fq.size() == 0) begin
                    n_bad++;
                    $display("FAIL overread: re=%b fifo_size=%0d need>0",
                             fifo_re_o, fq.size());
                end
                if (busy) begin
                    cyc++;
                    if (fifo_re_o) rd_cnt++;
                    if (stall_o) stall_cnt++;
                    if (data_valid_o) begin
                        check("data", int'(data_o), int'(exp_data));
                        busy = 1'b0;
                        done = 1'b1;
                    end
                end else begin
                    check("idle_outs",
                          int'({data_valid_o, fifo_re_o, stall_o}), 0);
                end
            end
        end
    endtask

    task automatic fifo_push(input logic [7:0] b);
        push_en   = 1'b1;
        push_byte = b;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        stream.push_back(b);
        fifo_push(b);
    endtask

    task automatic start_req(input int n, input bit fl, input int lit);
        logic [14:0] e;
        int          need;
        if (fl) bits.delete();
        need = 0;
        while (bits.size() < n && rd_ptr < stream.size()) begin
            for (int k = 0; k < 8; k++) bits.push_back(stream[rd_ptr][k]);
            rd_ptr++;
            need++;
        end
        e = '0;
        if (bits.size() >= n) begin
            for (int k = 0; k < n; k++) e[k] = bits.pop_front();
        end
        exp_data  = e;
        exp_reads = need;
        if (lit >= 0) check("model_data", int'(e), lit);
        req      = 1'b1;
        req_bits = n[3:0];
        flush    = fl;
        @(posedge clk);
        busy      = 1'b1;
        done      = 1'b0;
        cyc       = 0;
        rd_cnt    = 0;
        stall_cnt = 0;
        @(negedge clk);
        req   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_done(input int lat, input int reads, input bit nostall);
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: valid not seen, got 0 expected 1");
        end else begin
            if (lat > 0) check("latency", cyc, lat);
            check("model_reads", exp_reads, reads);
            check("reads", rd_cnt, exp_reads);
            if (nostall) check("stall_cycles", stall_cnt, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        busy = 0; done = 0; cyc = 0; rd_cnt = 0; stall_cnt = 0;
        rd_ptr = 0; exp_data = '0; exp_reads = 0;
        reset = 1'b0; req = 1'b0; req_bits = '0; flush = 1'b0;
        push_en = 1'b0; push_byte = '0; fdata = '0; favail = 1'b0;
        fork
            monitor();
        join_none

        @(negedge clk);
        put(8'hAA); put(8'h55); put(8'h12); put(8'h34);
        check("rst_re", int'(fifo_re_o), 0);
        check("rst_valid", int'(data_valid_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_stall", int'(stall_o), 0);
        check("rst_ready", int'(ready_o), 1);
        reset = 1'b1;
        @(negedge clk);

        start_req(4, 0, 'hA);      wait_done(3, 1, 1);
        start_req(8, 0, 'h5A);     wait_done(3, 1, 1);
        start_req(15, 0, 'h4125);  wait_done(4, 2, 1);

        put(8'h03);
        start_req(2, 1, 'h3);      wait_done(3, 1, 1);

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bits.delete();

        stream.push_back(8'h07);
        start_req(3, 0, 'h7);
        repeat (2) @(negedge clk);
        check("stall_high", int'(stall_o), 1);
        check("stall_re", int'(fifo_re_o), 0);
        fifo_push(8'h07);
        wait_done(-1, 1, 0);
        check("stall_seen", int'(stall_cnt != 0), 1);
        check("stall_low", int'(stall_o), 0);

        start_req(0, 0, 'h0);      wait_done(1, 0, 1);
        start_req(4, 0, 'h0);      wait_done(1, 0, 1);

        start_req(15, 0, -1);
        repeat (2) @(negedge clk);
        check("pre_rst_stall", int'(stall_o), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_re", int'(fifo_re_o), 0);
        check("mid_rst_valid", int'(data_valid_o), 0);
        check("mid_rst_data", int'(data_o), 0);
        check("mid_rst_stall", int'(stall_o), 0);
        check("mid_rst_ready", int'(ready_o), 1);
        busy = 1'b0;
        bits.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        put(8'hC3);
        start_req(8, 0, 'hC3);     wait_done(3, 1, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_bit_fetch.md
Name: fifo_bit_fetch

Overview:
- Read-side controller for the encoder's byte FIFO.
- Serves per-tone requests of 0..15 bits by popping bytes from the FIFO.
- Bytes are packed LSB-first into a residual bit buffer; the requested bits are then delivered to the constellation encoder.
- Sits between the data FIFO and the tone-order/constellation mapper. Owns the FIFO read enable and never over-reads.

Parameters:
DWIDTH, 8, FIFO data width (byte); fixed at 8 for this block
BWIDTH, 4, width of bit-count request; max request 2**BWIDTH-1 = 15
OWIDTH, 15, width of data_o; must equal 2**BWIDTH-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fifo_one_available_i  in  1  FIFO holds at least one entry (reflects reads of the previous edge)
fifo_data_i  in  DWIDTH  FIFO read data, valid the cycle after fifo_re_o was high
fifo_re_o  out  1  FIFO read enable
req_i  in  1  bit request strobe
req_bits_i  in  BWIDTH  number of bits requested (0..15)
flush_i  in  1  discard residual bits (frame boundary)
ready_o  out  1  block idle, request accepted this cycle if req_i high
data_valid_o  out  1  one-cycle pulse, data_o valid
data_o  out  OWIDTH  requested bits, right-aligned, upper bits zero
stall_o  out  1  waiting on an empty FIFO

Behaviour:
- Reset (reset low, async): state IDLE; buffer=0; fill=0; fifo_re_o=0, data_valid_o=0, data_o=0, stall_o=0, ready_o=1 after release.
- Storage: 23-bit bit buffer plus 5-bit fill count. Invariant: fill<=7 in IDLE.
- States:
  - IDLE: ready_o=1. On req_i, latch n=req_bits_i. If n<=fill, go to OUT; else compute need=ceil((n-fill)/8) in {1,2}, set issued=0, and go to FETCH.
  - FETCH:
    - fifo_re_o = (issued<need) && fifo_one_available_i, combinational.
    - Each re increments issued.
    - The byte arriving the following cycle is written to buffer[fill+:8]; fill+=8.
    - When captured==need, go to OUT.
    - stall_o = (issued<need) && !fifo_one_available_i.
    - Back-to-back reads are allowed.
  - OUT: data_valid_o=1; data_o = buffer[n-1:0] zero-extended; buffer>>=n; fill-=n; go to IDLE.
- Latency, counted from the acceptance edge (cycle C0):
  - n<=fill: valid in C1.
  - 1 byte, FIFO non-empty: re in C1, capture end of C2, valid in C3.
  - 2 bytes: re in C1 and C2, valid in C4.
- n=0: OUT with data_o=0, no FIFO read.
- flush_i:
  - Honoured only in IDLE; clears buffer and fill.
  - If req_i is high in the same cycle, the request is evaluated with fill=0.
  - Ignored in other states.
- req_i outside IDLE is ignored (ready_o=0).
- Reset mid-FETCH discards the in-flight byte; the FIFO side is not rewound.

Decomposition:
- Shared package:
  - state encoding (IDLE, FETCH, OUT)
  - DWIDTH/BWIDTH/OWIDTH constants
  - buffer width 23, fill width 5
- No sub-module needed. The bit buffer with insert-at-offset and shift-right-by-n stays in one always block.

Test Plan:
- Reset with FIFO {AA,55,12,34}, then req 4 -> 1 re; data_o=0xA valid in C3; fill=4; then req 8 -> 1 re, data_o=0x5A, fill=4 (residual 0x5).
- Continue: req 15 -> 2 back-to-back re; data_o=0x4125 valid in C4; fill=5, residual 0x06; stall_o never high.
- FIFO empty, fill=0, req 3 -> stall_o=1, fifo_re_o=0; write 0x07 -> re the cycle one_available rises; data_o=0x7; stall_o drops.
- fill=5, flush_i+req 2 same cycle, FIFO {03} -> residual discarded, 1 re, data_o=0x3, fill=6.
- req 0 and req n<=fill -> data_valid_o in C1, no fifo_re_o; reset asserted mid-FETCH -> all outputs 0 immediately, ready_o=1, fill=0 after release.
